// File: rtl/axi_burst_mem_slave.sv
// AXI4 memory slave with FIXED/INCR/WRAP bursts, narrow lane masking, per-beat range decode
// and WLAST checking. Independent write (AW/W/B) and read (AR/R) engines share one array.
module axi_burst_mem_slave #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    axi_ACLK,
    input  logic                    axi_ARESETn,
    input  logic                    axi_AWVALID,
    output logic                    axi_AWREADY,
    input  logic [ID_WIDTH-1:0]     axi_AWID,
    input  logic [ADDR_WIDTH-1:0]   axi_AWADDR,
    input  logic [LEN_WIDTH-1:0]    axi_AWLEN,
    input  logic [2:0]              axi_AWSIZE,
    input  logic [1:0]              axi_AWBURST,
    input  logic                    axi_WVALID,
    output logic                    axi_WREADY,
    input  logic [DATA_WIDTH-1:0]   axi_WDATA,
    input  logic [DATA_WIDTH/8-1:0] axi_WSTRB,
    input  logic                    axi_WLAST,
    output logic                    axi_BVALID,
    input  logic                    axi_BREADY,
    output logic [ID_WIDTH-1:0]     axi_BID,
    output logic [1:0]              axi_BRESP,
    input  logic                    axi_ARVALID,
    output logic                    axi_ARREADY,
    input  logic [ID_WIDTH-1:0]     axi_ARID,
    input  logic [ADDR_WIDTH-1:0]   axi_ARADDR,
    input  logic [LEN_WIDTH-1:0]    axi_ARLEN,
    input  logic [2:0]              axi_ARSIZE,
    input  logic [1:0]              axi_ARBURST,
    output logic                    axi_RVALID,
    input  logic                    axi_RREADY,
    output logic [ID_WIDTH-1:0]     axi_RID,
    output logic [DATA_WIDTH-1:0]   axi_RDATA,
    output logic [1:0]              axi_RRESP,
    output logic                    axi_RLAST
);

    localparam int unsigned NB        = DATA_WIDTH / 8;
    localparam int unsigned LSB       = $clog2(NB);
    localparam int unsigned WORD_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned MEM_BYTES = MEM_DEPTH * NB;

    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {StWIdle, StWData, StWResp} wstate_e;
    typedef enum logic {StRIdle, StRData} rstate_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0]            size,
                                                        input logic [LEN_WIDTH-1:0]  len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        mask = ADDR_WIDTH'((32'(len) + 32'd1) << size) - ADDR_WIDTH'(1);
        case (burst)
            BurstIncr: next_addr = addr + step;
            BurstWrap: next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:   next_addr = addr;
        endcase
    endfunction

    // Whole-burst configuration error: reserved type, oversize beat or malformed wrap.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [2:0]            size,
                                       input logic [LEN_WIDTH-1:0]  len,
                                       input logic [1:0]            burst);
        logic len_ok;
        logic aligned;
        len_ok  = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                  (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
        aligned = (addr & ((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1))) == '0;
        burst_err = (burst == BurstRsvd) || (32'(size) > LSB) ||
                    ((burst == BurstWrap) && !(len_ok && aligned));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        in_range = 32'(addr) < MEM_BYTES;
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] addr,
                                                input logic [2:0]            size);
        int unsigned lo;
        int unsigned nbytes;
        nbytes = 32'd1 << size;
        lo     = 32'(addr) & (NB - 1) & ~(nbytes - 1);
        for (int unsigned i = 0; i < NB; i++) begin
            lane_mask[i] = (i >= lo) && (i < lo + nbytes);
        end
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    wstate_e               wstate_q;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [LEN_WIDTH-1:0]  wlen_q;
    logic [LEN_WIDTH-1:0]  wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic                  wcfg_err_q;
    logic                  wslv_q;
    logic                  wdec_q;
    logic                  wover_q;

    logic                  w_beat;
    logic                  w_take;
    logic                  w_inrange;
    logic                  w_dec_beat;
    logic                  w_early;
    logic                  wr_en;
    logic [NB-1:0]         wr_be;
    logic [1:0]            w_resp;

    always_comb begin
        w_beat     = (wstate_q == StWData) && axi_WVALID && axi_WREADY;
        // Beats past the announced length are drained without touching memory.
        w_take     = w_beat && !wover_q;
        w_inrange  = in_range(waddr_q);
        w_dec_beat = w_take && !wcfg_err_q && !w_inrange;
        wr_en      = w_take && !wcfg_err_q && w_inrange;
        wr_be      = axi_WSTRB & lane_mask(waddr_q, wsize_q);
        w_early    = w_take && axi_WLAST && (wcnt_q != wlen_q);
        if (wdec_q || w_dec_beat) begin
            w_resp = RespDecerr;
        end else if (wslv_q || wcfg_err_q || w_early) begin
            w_resp = RespSlverr;
        end else begin
            w_resp = RespOkay;
        end
    end

    always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
        if (!axi_ARESETn) begin
            wstate_q    <= StWIdle;
            axi_AWREADY <= 1'b1;
            axi_WREADY  <= 1'b0;
            axi_BVALID  <= 1'b0;
            axi_BID     <= '0;
            axi_BRESP   <= RespOkay;
            wid_q       <= '0;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wsize_q     <= '0;
            wburst_q    <= '0;
            wcfg_err_q  <= 1'b0;
            wslv_q      <= 1'b0;
            wdec_q      <= 1'b0;
            wover_q     <= 1'b0;
        end else begin
            case (wstate_q)
                StWIdle: begin
                    if (axi_AWVALID) begin
                        wid_q       <= axi_AWID;
                        waddr_q     <= axi_AWADDR;
                        wlen_q      <= axi_AWLEN;
                        wsize_q     <= axi_AWSIZE;
                        wburst_q    <= axi_AWBURST;
                        wcfg_err_q  <= burst_err(axi_AWADDR, axi_AWSIZE, axi_AWLEN, axi_AWBURST);
                        wcnt_q      <= '0;
                        wslv_q      <= 1'b0;
                        wdec_q      <= 1'b0;
                        wover_q     <= 1'b0;
                        axi_AWREADY <= 1'b0;
                        axi_WREADY  <= 1'b1;
                        wstate_q    <= StWData;
                    end
                end
                StWData: begin
                    if (w_beat) begin
                        if (w_take) begin
                            waddr_q <= next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                            if (w_dec_beat) wdec_q <= 1'b1;
                            if (wcnt_q != wlen_q) wcnt_q <= wcnt_q + LEN_WIDTH'(1);
                        end
                        if (axi_WLAST) begin
                            axi_WREADY <= 1'b0;
                            axi_BVALID <= 1'b1;
                            axi_BID    <= wid_q;
                            axi_BRESP  <= w_resp;
                            wstate_q   <= StWResp;
                        end else if (w_take && (wcnt_q == wlen_q)) begin
                            wslv_q  <= 1'b1;
                            wover_q <= 1'b1;
                        end
                    end
                end
                StWResp: begin
                    if (axi_BREADY) begin
                        axi_BVALID  <= 1'b0;
                        axi_AWREADY <= 1'b1;
                        wstate_q    <= StWIdle;
                    end
                end
                default: wstate_q <= StWIdle;
            endcase
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge axi_ACLK) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[waddr_q[LSB +: WORD_W]][8*i +: 8] <= axi_WDATA[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_e               rstate_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [LEN_WIDTH-1:0]  rlen_q;
    logic [LEN_WIDTH-1:0]  rcnt_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic                  rcfg_err_q;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    // Beat to present next: the AR address in idle, otherwise the sequenced address.
    always_comb begin
        if (rstate_q == StRIdle) begin
            rd_addr = axi_ARADDR;
            rd_err  = burst_err(axi_ARADDR, axi_ARSIZE, axi_ARLEN, axi_ARBURST);
        end else begin
            rd_addr = raddr_q;
            rd_err  = rcfg_err_q;
        end
        rd_data = '0;
        rd_resp = RespOkay;
        if (rd_err) begin
            rd_resp = RespSlverr;
        end else if (!in_range(rd_addr)) begin
            rd_resp = RespDecerr;
        end else begin
            rd_data = mem[rd_addr[LSB +: WORD_W]];
        end
    end

    always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
        if (!axi_ARESETn) begin
            rstate_q    <= StRIdle;
            axi_ARREADY <= 1'b1;
            axi_RVALID  <= 1'b0;
            axi_RID     <= '0;
            axi_RDATA   <= '0;
            axi_RRESP   <= RespOkay;
            axi_RLAST   <= 1'b0;
            raddr_q     <= '0;
            rlen_q      <= '0;
            rcnt_q      <= '0;
            rsize_q     <= '0;
            rburst_q    <= '0;
            rcfg_err_q  <= 1'b0;
        end else begin
            case (rstate_q)
                StRIdle: begin
                    if (axi_ARVALID) begin
                        rlen_q      <= axi_ARLEN;
                        rsize_q     <= axi_ARSIZE;
                        rburst_q    <= axi_ARBURST;
                        rcfg_err_q  <= rd_err;
                        raddr_q     <= next_addr(axi_ARADDR, axi_ARSIZE, axi_ARLEN, axi_ARBURST);
                        rcnt_q      <= LEN_WIDTH'(1);
                        axi_RID     <= axi_ARID;
                        axi_RDATA   <= rd_data;
                        axi_RRESP   <= rd_resp;
                        axi_RLAST   <= (axi_ARLEN == '0);
                        axi_RVALID  <= 1'b1;
                        axi_ARREADY <= 1'b0;
                        rstate_q    <= StRData;
                    end
                end
                StRData: begin
                    if (axi_RREADY) begin
                        if (axi_RLAST) begin
                            axi_RVALID  <= 1'b0;
                            axi_RLAST   <= 1'b0;
                            axi_ARREADY <= 1'b1;
                            rstate_q    <= StRIdle;
                        end else begin
                            axi_RDATA <= rd_data;
                            axi_RRESP <= rd_resp;
                            axi_RLAST <= (rcnt_q == rlen_q);
                            raddr_q   <= next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
                            rcnt_q    <= rcnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                default: rstate_q <= StRIdle;
            endcase
        end
    end

endmodule
